// File: rtl/wb_retire_stage.sv
// Writeback stage: in-order retire queue between MEM and the GPR file, with head retire, debug trace and youngest-match forwarding.
// Latency: an entry reaches the head one cycle after acceptance. Backpressure: ws_allowin drops only when the queue is full and the head cannot retire.
module wb_retire_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_to_ws_valid,
    input  logic                       ms_gr_we,
    input  logic [ADDR_W-1:0]          ms_dest,
    input  logic [DATA_W-1:0]          ms_result,
    input  logic [PC_W-1:0]            ms_pc,
    output logic                       ws_allowin,
    input  logic                       ws_flush,
    input  logic                       rf_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic [ADDR_W-1:0]          ds_rs1,
    input  logic [ADDR_W-1:0]          ds_rs2,
    output logic                       fwd1_hit,
    output logic [DATA_W-1:0]          fwd1_data,
    output logic                       fwd2_hit,
    output logic [DATA_W-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]     ws_count,
    output logic [PC_W-1:0]            debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [ADDR_W-1:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]          debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              gr_we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] result;
        logic [PC_W-1:0]   pc;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    ent_t             head_ent;
    logic             non_empty;
    logic             head_we_eff;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] idx;

    always_comb begin
        head_ent    = ent_q[head_q];
        non_empty   = (count_q != '0);
        head_we_eff = head_ent.gr_we && (head_ent.dest != '0);
        // Non-writing entries drain regardless of the write port.
        pop         = non_empty && !ws_flush && (!head_we_eff || rf_ready);
        rf_we       = non_empty && !ws_flush && head_we_eff && rf_ready;
        ws_allowin  = (count_q < CNT_W'(DEPTH)) || pop;
        push        = ms_to_ws_valid && ws_allowin && !ws_flush;
    end

    assign rf_waddr          = head_ent.dest;
    assign rf_wdata          = head_ent.result;
    assign ws_count          = count_q;
    assign debug_wb_pc       = head_ent.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (ws_flush) begin
            vld_d   = '0;
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (pop) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_W'(1);
            end
            if (push) begin
                vld_d[tail_q] = 1'b1;
                ent_d[tail_q] = '{gr_we: ms_gr_we, dest: ms_dest, result: ms_result, pc: ms_pc};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Walk from head to tail so the youngest matching producer wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (vld_q[idx] && ent_q[idx].gr_we && ent_q[idx].dest != '0) begin
                if (ent_q[idx].dest == ds_rs1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = ent_q[idx].result;
                end
                if (ent_q[idx].dest == ds_rs2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = ent_q[idx].result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: expected register-file writes are queued as stimulus is
// accepted and popped by a monitor whenever the DUT asserts rf_we.
module tb_wb_retire_stage;

    logic        clk;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic [31:0] ms_pc;
    logic        ws_allowin;
    logic        ws_flush;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ds_rs1;
    logic [4:0]  ds_rs2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [1:0]  ws_count;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t exp_wr;
    int  total = 0;
    int  bad   = 0;

    wb_retire_stage #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_pc             (ms_pc),
        .ws_allowin        (ws_allowin),
        .ws_flush          (ws_flush),
        .rf_ready          (rf_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ds_rs1            (ds_rs1),
        .ds_rs2            (ds_rs2),
        .fwd1_hit          (fwd1_hit),
        .fwd1_data         (fwd1_data),
        .fwd2_hit          (fwd2_hit),
        .fwd2_data         (fwd2_data),
        .ws_count          (ws_count),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Every write the DUT performs must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (resetn && rf_we) begin
            if (sb.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_write got waddr=%0d wdata=0x%0h, expected no write", rf_waddr, rf_wdata);
            end else begin
                exp_wr = sb.pop_front();
                total = total + 1;
                if (rf_waddr !== exp_wr.dest) begin
                    bad = bad + 1;
                    $display("FAIL wr_addr got %0d expected %0d", rf_waddr, exp_wr.dest);
                end
                total = total + 1;
                if (rf_wdata !== exp_wr.data) begin
                    bad = bad + 1;
                    $display("FAIL wr_data got 0x%0h expected 0x%0h", rf_wdata, exp_wr.data);
                end
                total = total + 1;
                if (debug_wb_rf_wen !== 4'hf || debug_wb_rf_wnum !== exp_wr.dest || debug_wb_rf_wdata !== exp_wr.data) begin
                    bad = bad + 1;
                    $display("FAIL wr_debug got wen=%h wnum=%0d wdata=0x%0h expected wen=f wnum=%0d wdata=0x%0h",
                             debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, exp_wr.dest, exp_wr.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ms(input logic v, input logic we, input logic [4:0] d,
                          input logic [31:0] r, input logic [31:0] pc);
        ms_to_ws_valid = v;
        ms_gr_we       = we;
        ms_dest        = d;
        ms_result      = r;
        ms_pc          = pc;
    endtask

    task automatic exp_push(input logic [4:0] d, input logic [31:0] r);
        wr_t w;
        w.dest = d;
        w.data = r;
        sb.push_back(w);
    endtask

    task automatic chk_count(input string name, input logic [1:0] exp);
        total = total + 1;
        if (ws_count !== exp) begin
            bad = bad + 1;
            $display("FAIL %s ws_count got %0d expected %0d", name, ws_count, exp);
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        ws_flush = 1'b0;
        rf_ready = 1'b0;
        ds_rs1   = 5'd0;
        ds_rs2   = 5'd0;
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #12;
        chk_count("reset", 2'd0);
        total = total + 1;
        if (ws_allowin !== 1'b1 || rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
            bad = bad + 1;
            $display("FAIL reset_ctl got allowin=%b rf_we=%b wen=%h expected 1 0 0", ws_allowin, rf_we, debug_wb_rf_wen);
        end
        total = total + 1;
        if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0 || fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin
            bad = bad + 1;
            $display("FAIL reset_fwd got %b/%h %b/%h expected 0/0 0/0", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        step();
        resetn = 1'b1;
    endtask

    task automatic test_single();
        step();
        rf_ready = 1'b1;
        set_ms(1'b1, 1'b1, 5'd5, 32'h1234, 32'h1c000000);
        exp_push(5'd5, 32'h1234);
        @(negedge clk);
        chk_count("single_accept", 2'd0);
        total = total + 1;
        if (ws_allowin !== 1'b1 || rf_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL single_accept got allowin=%b rf_we=%b expected 1 0", ws_allowin, rf_we);
        end
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("single_head", 2'd1);
        total = total + 1;
        if (rf_we !== 1'b1 || debug_wb_pc !== 32'h1c000000) begin
            bad = bad + 1;
            $display("FAIL single_retire got rf_we=%b pc=0x%0h expected 1 0x1c000000", rf_we, debug_wb_pc);
        end
        step();
        @(negedge clk);
        chk_count("single_drained", 2'd0);
        total = total + 1;
        if (rf_we !== 1'b0 || sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL single_done got rf_we=%b pending=%0d expected 0 0", rf_we, sb.size());
        end
    endtask

    task automatic test_full_fwd();
        step();
        rf_ready = 1'b0;
        ds_rs1   = 5'd3;
        ds_rs2   = 5'd7;
        set_ms(1'b1, 1'b1, 5'd3, 32'hA, 32'h1c000100);
        exp_push(5'd3, 32'hA);
        step();
        set_ms(1'b1, 1'b1, 5'd3, 32'hB, 32'h1c000104);
        exp_push(5'd3, 32'hB);
        step();
        set_ms(1'b1, 1'b1, 5'd7, 32'hC, 32'h1c000108);
        @(negedge clk);
        chk_count("full", 2'd2);
        total = total + 1;
        if (ws_allowin !== 1'b0 || rf_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL full_stall got allowin=%b rf_we=%b expected 0 0", ws_allowin, rf_we);
        end
        total = total + 1;
        if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hB) begin
            bad = bad + 1;
            $display("FAIL fwd_youngest got %b/0x%0h expected 1/0xb", fwd1_hit, fwd1_data);
        end
        total = total + 1;
        if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin
            bad = bad + 1;
            $display("FAIL fwd_not_queued got %b/0x%0h expected 0/0", fwd2_hit, fwd2_data);
        end
        step();
        rf_ready = 1'b1;
        exp_push(5'd7, 32'hC);
        @(negedge clk);
        total = total + 1;
        if (ws_allowin !== 1'b1 || rf_we !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL full_pop got allowin=%b rf_we=%b expected 1 1", ws_allowin, rf_we);
        end
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("after_swap", 2'd2);
        total = total + 1;
        if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hC || fwd1_hit !== 1'b1 || fwd1_data !== 32'hB) begin
            bad = bad + 1;
            $display("FAIL fwd_head_writing got %b/0x%0h %b/0x%0h expected 1/0xb 1/0xc",
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        step();
        step();
        @(negedge clk);
        chk_count("full_drained", 2'd0);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL full_pending got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        step();
        rf_ready = 1'b0;
        ds_rs1   = 5'd0;
        ds_rs2   = 5'd0;
        set_ms(1'b1, 1'b1, 5'd10, 32'h100, 32'h1c000200);
        exp_push(5'd10, 32'h100);
        step();
        set_ms(1'b1, 1'b1, 5'd11, 32'h101, 32'h1c000204);
        exp_push(5'd11, 32'h101);
        step();
        rf_ready = 1'b1;
        set_ms(1'b1, 1'b1, 5'd12, 32'h102, 32'h1c000208);
        exp_push(5'd12, 32'h102);
        @(negedge clk);
        chk_count("b2b_full", 2'd2);
        total = total + 1;
        if (ws_allowin !== 1'b1 || rf_we !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_allowin got allowin=%b rf_we=%b expected 1 1", ws_allowin, rf_we);
        end
        step();
        set_ms(1'b1, 1'b1, 5'd13, 32'h103, 32'h1c00020c);
        exp_push(5'd13, 32'h103);
        @(negedge clk);
        chk_count("b2b_steady", 2'd2);
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("b2b_hold", 2'd2);
        step();
        step();
        @(negedge clk);
        chk_count("b2b_drained", 2'd0);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL b2b_pending got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_zero_dest();
        step();
        rf_ready = 1'b0;
        set_ms(1'b1, 1'b1, 5'd0, 32'hFFFF, 32'h1c000040);
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        ds_rs1 = 5'd0;
        ds_rs2 = 5'd0;
        @(negedge clk);
        chk_count("zero_head", 2'd1);
        total = total + 1;
        if (rf_we !== 1'b0 || ws_allowin !== 1'b1 || debug_wb_pc !== 32'h1c000040) begin
            bad = bad + 1;
            $display("FAIL zero_retire got rf_we=%b allowin=%b pc=0x%0h expected 0 1 0x1c000040",
                     rf_we, ws_allowin, debug_wb_pc);
        end
        total = total + 1;
        if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin
            bad = bad + 1;
            $display("FAIL zero_fwd got %b/0x%0h expected 0/0", fwd1_hit, fwd1_data);
        end
        step();
        @(negedge clk);
        chk_count("zero_drained", 2'd0);
    endtask

    task automatic test_flush();
        step();
        rf_ready = 1'b0;
        ds_rs1   = 5'd20;
        ds_rs2   = 5'd21;
        set_ms(1'b1, 1'b1, 5'd20, 32'h200, 32'h1c000300);
        step();
        set_ms(1'b1, 1'b1, 5'd21, 32'h201, 32'h1c000304);
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("flush_full", 2'd2);
        total = total + 1;
        if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h200 || fwd2_hit !== 1'b1 || fwd2_data !== 32'h201) begin
            bad = bad + 1;
            $display("FAIL flush_prefwd got %b/0x%0h %b/0x%0h expected 1/0x200 1/0x201",
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        step();
        ws_flush = 1'b1;
        rf_ready = 1'b1;
        set_ms(1'b1, 1'b1, 5'd22, 32'h202, 32'h1c000308);
        @(negedge clk);
        total = total + 1;
        if (rf_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL flush_no_write got rf_we=%b expected 0", rf_we);
        end
        step();
        ws_flush = 1'b0;
        ds_rs1   = 5'd22;
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("flush_empty", 2'd0);
        total = total + 1;
        if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd2_data !== 32'h0 || rf_we !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL flush_after got %b %b/0x%0h rf_we=%b expected 0 0/0 0",
                     fwd1_hit, fwd2_hit, fwd2_data, rf_we);
        end
        step();
        @(negedge clk);
        chk_count("flush_mem_dropped", 2'd0);
    endtask

    task automatic test_async_reset();
        step();
        rf_ready = 1'b0;
        ds_rs1   = 5'd0;
        ds_rs2   = 5'd0;
        set_ms(1'b1, 1'b1, 5'd25, 32'h250, 32'h1c000400);
        step();
        set_ms(1'b1, 1'b1, 5'd26, 32'h260, 32'h1c000404);
        step();
        set_ms(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk_count("arst_full", 2'd2);
        step();
        rf_ready = 1'b1;
        #1;
        total = total + 1;
        if (rf_we !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL arst_pre got rf_we=%b expected 1", rf_we);
        end
        #1;
        resetn = 1'b0;
        #1;
        chk_count("arst_count", 2'd0);
        total = total + 1;
        if (rf_we !== 1'b0 || ws_allowin !== 1'b1 || debug_wb_rf_wen !== 4'h0) begin
            bad = bad + 1;
            $display("FAIL arst_ctl got rf_we=%b allowin=%b wen=%h expected 0 1 0", rf_we, ws_allowin, debug_wb_rf_wen);
        end
        step();
        resetn   = 1'b1;
        rf_ready = 1'b0;
        @(negedge clk);
        chk_count("arst_release", 2'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_fwd();
        test_back_to_back();
        test_zero_dest();
        test_flush();
        test_async_reset();
        step();
        step();
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL final_pending got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
